// File: rtl/adapt_uart_pkg.sv
// rtl/adapt_uart_pkg.sv - shared states, frame constants and pin indices for adapt_uart
package adapt_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_REPEAT
  } state_e;

  localparam int DATA_BITS  = 6;
  localparam int FRAME_BITS = 9;
  localparam int BIT_CNT_W  = $clog2(FRAME_BITS);

  localparam int UI_SER_EN    = 0;
  localparam int UI_IDLE_MODE = 1;
  localparam int UI_DATA_LSB  = 2;

  localparam int UO_TX          = 0;
  localparam int UO_BUSY        = 1;
  localparam int UO_REP_FLAG    = 2;
  localparam int UO_DONE        = 3;
  localparam int UO_REP_CNT_LSB = 4;

  localparam logic [3:0] REP_CNT_MAX = 4'd15;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == REP_CNT_MAX) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/adapt_uart_baud_gen.sv
// rtl/adapt_uart_baud_gen.sv - bit-time strobe generator, held at zero while cleared
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  output logic bit_tick_o
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign bit_tick_o = (cnt_q == CNT_LAST);

  // Restart on every bit boundary so each bit lasts exactly CLKS_PER_BIT cycles
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear_i || bit_tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/adapt_uart.sv
// rtl/adapt_uart.sv - 6-bit even-parity serial transmitter with repeat suppression
module adapt_uart
  import adapt_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  state_e                 state_q, state_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic [DATA_BITS-1:0]   last_data_q, last_data_d;
  logic                   last_valid_q, last_valid_d;
  logic                   par_q, par_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [3:0]             rep_cnt_q, rep_cnt_d;
  logic                   done_q, done_d;
  logic                   tx, busy, rep_flag;
  logic                   bit_tick;

  logic                   ser_en, idle_mode;
  logic [DATA_BITS-1:0]   data;
  logic                   unused_ok;

  assign ser_en    = ui_in[UI_SER_EN];
  assign idle_mode = ui_in[UI_IDLE_MODE];
  assign data      = ui_in[UI_DATA_LSB +: DATA_BITS];
  assign unused_ok = &{1'b0, ena, uio_in};

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk_i     (clk),
    .rst_i     (rst),
    .clear_i   (state_q == ST_IDLE),
    .bit_tick_o(bit_tick)
  );

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    last_data_d  = last_data_q;
    last_valid_d = last_valid_q;
    par_d        = par_q;
    bit_cnt_d    = bit_cnt_q;
    rep_cnt_d    = rep_cnt_q;
    done_d       = 1'b0;
    tx           = 1'b1;
    busy         = 1'b1;
    rep_flag     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        busy      = 1'b0;
        bit_cnt_d = '0;
        par_d     = 1'b0;
        if (ser_en) begin
          shreg_d = data;
          if (idle_mode && last_valid_q && (data == last_data_q)) begin
            state_d   = ST_REPEAT;
            rep_cnt_d = sat_inc(rep_cnt_q);
          end else begin
            state_d = ST_START;
          end
        end
      end
      ST_START: begin
        tx = 1'b0;
        if (bit_tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        tx = shreg_q[0];
        // Rotate rather than shift so the payload is intact again after the last bit
        if (bit_tick) begin
          shreg_d = {shreg_q[0], shreg_q[DATA_BITS-1:1]};
          par_d   = par_q ^ shreg_q[0];
          if (bit_cnt_q == BIT_CNT_W'(DATA_BITS - 1)) begin
            state_d   = ST_PARITY;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        tx = par_q;
        if (bit_tick) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (bit_tick) begin
          state_d      = ST_IDLE;
          done_d       = 1'b1;
          last_data_d  = shreg_q;
          last_valid_d = 1'b1;
          rep_cnt_d    = '0;
        end
      end
      ST_REPEAT: begin
        rep_flag = 1'b1;
        if (bit_tick) begin
          if (bit_cnt_q == BIT_CNT_W'(FRAME_BITS - 1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      last_data_q  <= '0;
      last_valid_q <= 1'b0;
      par_q        <= 1'b0;
      bit_cnt_q    <= '0;
      rep_cnt_q    <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      last_data_q  <= last_data_d;
      last_valid_q <= last_valid_d;
      par_q        <= par_d;
      bit_cnt_q    <= bit_cnt_d;
      rep_cnt_q    <= rep_cnt_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    uo_out                            = '0;
    uo_out[UO_TX]                     = tx;
    uo_out[UO_BUSY]                   = busy;
    uo_out[UO_REP_FLAG]               = rep_flag;
    uo_out[UO_DONE]                   = done_q;
    uo_out[UO_REP_CNT_LSB +: 4]       = rep_cnt_q;
  end

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_adapt_uart.sv
// tb/tb_adapt_uart.sv - directed self-checking bench for adapt_uart
module tb_adapt_uart;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int passed = 0;
  int total  = 0;

  localparam logic [8:0] SEQ_29 = 9'b111010010;
  localparam logic [8:0] SEQ_0F = 9'b100011110;

  adapt_uart #(.CLKS_PER_BIT(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total = total + 1;
    assert (got === exp) passed = passed + 1;
    else $error("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Entered on the first cycle of a frame; leaves on the done cycle without advancing
  task automatic run_frame(input logic [8:0] seq, input logic [3:0] cnt_during, input string tag);
    for (int i = 0; i < 18; i++) begin
      chk($sformatf("%s_c%0d", tag, i), uo_out, {cnt_during, 3'b001, seq[i/2]});
      tick();
    end
    chk({tag, "_done"}, uo_out, 8'h09);
  endtask

  task automatic run_repeat(input logic [3:0] cnt, input string tag);
    for (int i = 0; i < 18; i++) begin
      chk($sformatf("%s_c%0d", tag, i), uo_out, {cnt, 4'h7});
      tick();
    end
    chk({tag, "_done"}, uo_out, {cnt, 4'h9});
  endtask

  initial begin
    ena    = 1'b1;
    uio_in = 8'h00;
    rst    = 1'b1;
    ui_in  = 8'h01;
    tick();
    chk("rst_c0_uo", uo_out, 8'h01);
    tick();
    chk("rst_c1_uo", uo_out, 8'h01);
    chk("rst_oe", uio_oe, 8'h00);
    chk("rst_uio_out", uio_out, 8'h00);

    rst   = 1'b0;
    ui_in = 8'hA5;
    tick();
    ui_in = 8'h00;
    run_frame(SEQ_29, 4'd0, "f29");
    tick();
    chk("idle_after_done", uo_out, 8'h01);

    ui_in = 8'hA7;
    tick();
    run_repeat(4'd1, "rep1");
    tick();
    run_repeat(4'd2, "rep2");

    ui_in = 8'h3D;
    tick();
    run_frame(SEQ_0F, 4'd2, "f0f");

    ui_in = 8'h3F;
    for (int k = 1; k <= 17; k++) begin
      tick();
      run_repeat((k > 15) ? 4'd15 : 4'(k), $sformatf("sat%0d", k));
    end

    ui_in = 8'h3D;
    tick();
    chk("mid_start", uo_out, 8'hF2);
    for (int i = 0; i < 5; i++) tick();
    chk("mid_data", uo_out, 8'hF3);
    rst = 1'b1;
    tick();
    chk("mid_rst", uo_out, 8'h01);
    rst   = 1'b0;
    ui_in = 8'h3F;
    tick();
    run_frame(SEQ_0F, 4'd0, "after_rst");
    ui_in = 8'h00;
    tick();
    chk("end_idle", uo_out, 8'h01);
    chk("end_oe", uio_oe, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
